// File: rtl/exe_stage.sv
// Execute stage: bus register, single-cycle ALU, iterative divider and
// data-SRAM request generation for ld.w/st.w.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [151:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [4:0]   EXE_dest,
    output logic         exe_gr_we,
    output logic         exe_res_from_mem
);

    localparam int DS_TO_ES_BUS_WD = 152;
    localparam int ES_TO_MS_BUS_WD = 71;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    logic                       r_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] r_bus;
    logic                       w_ready_go;

    logic [11:0] w_alu_op;
    logic [3:0]  w_div_op;
    logic        w_load_op;
    logic        w_mem_we;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_rkd;
    logic [31:0] w_pc;

    assign {w_alu_op, w_div_op, w_load_op, w_mem_we, w_gr_we, w_dest,
            w_src1, w_src2, w_rkd, w_pc} = r_bus;

    // ---------------- handshake and bus register ----------------
    assign es_allowin     = !r_es_valid || (w_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ds_to_es_valid && es_allowin) begin
            r_bus <= ds_to_es_bus;
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_alu_res;

    assign w_add  = w_src1 + w_src2;
    assign w_sub  = w_src1 - w_src2;
    assign w_slt  = {31'd0, $signed(w_src1) < $signed(w_src2)};
    assign w_sltu = {31'd0, w_src1 < w_src2};
    assign w_sll  = w_src1 << w_src2[4:0];
    assign w_srl  = w_src1 >> w_src2[4:0];
    assign w_sra  = $signed(w_src1) >>> w_src2[4:0];

    // one-hot AND-OR select; an all-zero op naturally yields 0
    assign w_alu_res = ({32{w_alu_op[0]}}  & w_add)
                     | ({32{w_alu_op[1]}}  & w_sub)
                     | ({32{w_alu_op[2]}}  & w_slt)
                     | ({32{w_alu_op[3]}}  & w_sltu)
                     | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                     | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                     | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                     | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                     | ({32{w_alu_op[8]}}  & w_sll)
                     | ({32{w_alu_op[9]}}  & w_srl)
                     | ({32{w_alu_op[10]}} & w_sra)
                     | ({32{w_alu_op[11]}} & w_src2);

    // ---------------- divider ----------------
    div_state_t  r_state;
    div_state_t  w_next;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_qneg;
    logic        r_rneg;

    logic        w_div_any;
    logic        w_signed;
    logic        w_start;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic        w_ge;

    assign w_div_any = |w_div_op;
    assign w_signed  = w_div_op[0] | w_div_op[1];
    assign w_start   = r_es_valid && w_div_any;
    assign w_abs1    = (w_signed && w_src1[31]) ? (~w_src1 + 32'd1) : w_src1;
    assign w_abs2    = (w_signed && w_src2[31]) ? (~w_src2 + 32'd1) : w_src2;

    // partial remainder can reach 33 bits when the divisor is above 2^31
    assign w_rem_sh = {r_rem, r_dvd[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    assign w_ge     = !w_diff[33];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_BUSY;
            S_BUSY: if (r_cnt == 5'd31) w_next = S_DONE;
            S_DONE: if (es_to_ms_valid && ms_allowin) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // quotient bits shift into the low end of the dividend register
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_start) begin
            r_dvd  <= w_abs1;
            r_dvs  <= w_abs2;
            r_rem  <= 32'd0;
            r_cnt  <= 5'd0;
            r_qneg <= w_signed && (w_src1[31] ^ w_src2[31]);
            r_rneg <= w_signed && w_src1[31];
        end else if (r_state == S_BUSY) begin
            r_rem <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
            r_dvd <= {r_dvd[30:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
        end
    end

    logic        w_dvz;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_div_res;
    logic [31:0] w_result;

    assign w_dvz = (w_src2 == 32'd0);
    assign w_quo = w_dvz ? 32'hFFFF_FFFF
                 : (r_qneg ? (~r_dvd + 32'd1) : r_dvd);
    assign w_rem = w_dvz ? w_src1
                 : (r_rneg ? (~r_rem + 32'd1) : r_rem);

    assign w_div_res = (w_div_op[0] | w_div_op[2]) ? w_quo : w_rem;
    assign w_result  = w_div_any ? w_div_res : w_alu_res;

    assign w_ready_go = !w_div_any || (r_state == S_DONE);

    // ---------------- memory request and outputs ----------------
    assign data_sram_en    = r_es_valid && (w_load_op || w_mem_we);
    assign data_sram_we    = {4{r_es_valid && w_mem_we}};
    assign data_sram_addr  = w_add;
    assign data_sram_wdata = w_rkd;

    logic [ES_TO_MS_BUS_WD-1:0] w_ms_bus;

    assign w_ms_bus     = {w_load_op, w_gr_we, w_dest, w_result, w_pc};
    assign es_to_ms_bus = w_ms_bus;

    assign EXE_dest         = w_dest & {5{r_es_valid}};
    assign exe_gr_we        = r_es_valid && w_gr_we;
    assign exe_res_from_mem = r_es_valid && w_load_op;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: cycle-level reference model plus directed vectors.
`define CHK(n, a, e) chk(n, 71'(a), 71'(e))

module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [151:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   EXE_dest;
    logic         exe_gr_we;
    logic         exe_res_from_mem;

    exe_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ms_allowin       (ms_allowin),
        .es_allowin       (es_allowin),
        .ds_to_es_valid   (ds_to_es_valid),
        .ds_to_es_bus     (ds_to_es_bus),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .EXE_dest         (EXE_dest),
        .exe_gr_we        (exe_gr_we),
        .exe_res_from_mem (exe_res_from_mem)
    );

    localparam logic [11:0] ADD  = 12'h001, SUB = 12'h002, SLT = 12'h004;
    localparam logic [11:0] SLTU = 12'h008, AND = 12'h010, NOR = 12'h020;
    localparam logic [11:0] OR   = 12'h040, XOR = 12'h080, SLL = 12'h100;
    localparam logic [11:0] SRL  = 12'h200, SRA = 12'h400, LUI = 12'h800;
    localparam logic [3:0]  DIVW = 4'h1, MODW = 4'h2, DIVWU = 4'h4, MODWU = 4'h8;

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [70:0] act,
                       input logic [70:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [151:0] mk(
        input logic [11:0] alu, input logic [3:0] dv, input logic ld,
        input logic we, input logic gw, input logic [4:0] d,
        input logic [31:0] s1, input logic [31:0] s2,
        input logic [31:0] rkd, input logic [31:0] pc);
        return {alu, dv, ld, we, gw, d, s1, s2, rkd, pc};
    endfunction

    // architectural result of one instruction, straight from the ISA rules
    function automatic logic [31:0] f_res(input logic [151:0] b);
        logic [11:0] alu;
        logic [3:0]  dv;
        logic [31:0] s1, s2;
        longint      a, d, q, r;
        alu = b[151:140];
        dv  = b[139:136];
        s1  = b[127:96];
        s2  = b[95:64];
        if (dv != 4'd0) begin
            if (s2 == 32'd0) return (dv[0] | dv[2]) ? 32'hFFFF_FFFF : s1;
            if (dv[0] | dv[1]) begin
                a = longint'($signed(s1));
                d = longint'($signed(s2));
            end else begin
                a = longint'({32'd0, s1});
                d = longint'({32'd0, s2});
            end
            q = a / d;
            r = a % d;
            return (dv[0] | dv[2]) ? q[31:0] : r[31:0];
        end
        if (alu[0])  return s1 + s2;
        if (alu[1])  return s1 - s2;
        if (alu[2])  return ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
        if (alu[3])  return (s1 < s2) ? 32'd1 : 32'd0;
        if (alu[4])  return s1 & s2;
        if (alu[5])  return ~(s1 | s2);
        if (alu[6])  return s1 | s2;
        if (alu[7])  return s1 ^ s2;
        if (alu[8])  return s1 << s2[4:0];
        if (alu[9])  return s1 >> s2[4:0];
        if (alu[10]) return 32'($signed(s1) >>> s2[4:0]);
        if (alu[11]) return s2;
        return 32'd0;
    endfunction

    // reference model: what ES holds and for how long
    logic         m_valid = 1'b0;
    logic [151:0] m_bus   = '0;
    int           m_age   = 0;

    always @(posedge clk) begin
        logic rdy, ain;
        rdy = (m_bus[139:136] == 4'd0) || (m_age >= 33);
        ain = !m_valid || (rdy && ms_allowin);
        if (reset) begin
            m_valid = 1'b0;
            m_age   = 0;
        end else if (ain) begin
            m_valid = ds_to_es_valid;
            if (ds_to_es_valid) m_bus = ds_to_es_bus;
            m_age = 0;
        end else if (m_age < 1000) begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        logic rdy, ov, ain, ld, st;
        rdy = (m_bus[139:136] == 4'd0) || (m_age >= 33);
        ov  = m_valid && rdy;
        ain = !m_valid || (rdy && ms_allowin);
        ld  = m_bus[135];
        st  = m_bus[134];
        `CHK("es_allowin", es_allowin, ain);
        `CHK("es_to_ms_valid", es_to_ms_valid, ov);
        `CHK("EXE_dest", EXE_dest, m_valid ? m_bus[132:128] : 5'd0);
        `CHK("exe_gr_we", exe_gr_we, m_valid && m_bus[133]);
        `CHK("exe_res_from_mem", exe_res_from_mem, m_valid && ld);
        `CHK("sram_en", data_sram_en, m_valid && (ld || st));
        `CHK("sram_we", data_sram_we, {4{m_valid && st}});
        if (m_valid && (ld || st)) begin
            `CHK("sram_addr", data_sram_addr, m_bus[127:96] + m_bus[95:64]);
            `CHK("sram_wdata", data_sram_wdata, m_bus[63:32]);
        end
        if (ov) begin
            `CHK("ms_bus", es_to_ms_bus,
                 {ld, m_bus[133], m_bus[132:128], f_res(m_bus), m_bus[31:0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [151:0] b);
        int   n;
        logic a;
        n = 0;
        ds_to_es_bus   = b;
        ds_to_es_valid = 1'b1;
        do begin
            @(negedge clk);
            a = es_allowin;
            step();
            n++;
        end while (!a && n < 200);
        ds_to_es_valid = 1'b0;
        if (!a) begin
            n_fail++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
    endtask

    // called in cycle 0 of a divide; ends at the negedge where it is offered
    task automatic run_div(input string nm, input logic [31:0] exp);
        int c;
        c = 0;
        @(negedge clk);
        while (!es_to_ms_valid && c < 60) begin
            step();
            @(negedge clk);
            c++;
        end
        `CHK({nm, "_latency"}, c, 33);
        `CHK(nm, es_to_ms_bus[63:32], exp);
    endtask

    logic [151:0] alu_vec [12];
    int           xfers;

    initial begin
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;

        // pin the model on hand-computed values
        `CHK("model_add", f_res(mk(ADD, 0, 0, 0, 1, 1, 5, 7, 0, 0)), 32'd12);
        `CHK("model_divw", f_res(mk(0, DIVW, 0, 0, 1, 1, 32'hFFFF_FFF9, 2, 0, 0)), 32'hFFFF_FFFD);
        `CHK("model_modw", f_res(mk(0, MODW, 0, 0, 1, 1, 32'hFFFF_FFF9, 2, 0, 0)), 32'hFFFF_FFFF);
        `CHK("model_modwu0", f_res(mk(0, MODWU, 0, 0, 1, 1, 32'h1234, 0, 0, 0)), 32'h1234);
        `CHK("model_ovf", f_res(mk(0, DIVW, 0, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0)), 32'h8000_0000);
        `CHK("model_sra", f_res(mk(SRA, 0, 0, 0, 1, 1, 32'h8000_0000, 4, 0, 0)), 32'hF800_0000);
        `CHK("model_sltu", f_res(mk(SLTU, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 1, 0, 0)), 32'd0);

        repeat (3) step();
        @(negedge clk);
        `CHK("rst_allowin", es_allowin, 1'b1);
        `CHK("rst_valid", es_to_ms_valid, 1'b0);
        `CHK("rst_dest", EXE_dest, 5'd0);
        `CHK("rst_sram_en", data_sram_en, 1'b0);
        step();
        reset = 1'b0;
        step();

        send(mk(ADD, 0, 0, 0, 1, 5'd3, 5, 7, 0, 32'h1C00_0000));
        @(negedge clk);
        `CHK("add_valid", es_to_ms_valid, 1'b1);
        `CHK("add_result", es_to_ms_bus[63:32], 32'd12);
        `CHK("add_dest", EXE_dest, 5'd3);
        step();

        send(mk(0, DIVW, 0, 0, 1, 5'd4, 32'hFFFF_FFF9, 2, 0, 32'h1C00_0004));
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (c < 33) begin
                `CHK("divw_busy_allowin", es_allowin, 1'b0);
                `CHK("divw_busy_valid", es_to_ms_valid, 1'b0);
            end else begin
                `CHK("divw_done_valid", es_to_ms_valid, 1'b1);
                `CHK("divw_result", es_to_ms_bus[63:32], 32'hFFFF_FFFD);
            end
            step();
        end

        send(mk(0, MODW, 0, 0, 1, 5'd5, 32'hFFFF_FFF9, 2, 0, 32'h1C00_0008));
        run_div("modw", 32'hFFFF_FFFF);
        step();
        send(mk(0, DIVWU, 0, 0, 1, 5'd6, 32'h55, 0, 0, 32'h1C00_000C));
        run_div("divwu_by0", 32'hFFFF_FFFF);
        step();
        send(mk(0, MODWU, 0, 0, 1, 5'd7, 32'h1234, 0, 0, 32'h1C00_0010));
        run_div("modwu_by0", 32'h1234);
        step();
        send(mk(0, DIVW, 0, 0, 1, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h1C00_0014));
        run_div("divw_ovf", 32'h8000_0000);
        step();

        send(mk(ADD, 0, 0, 1, 0, 5'd0, 32'h100, 4, 32'hDEAD_BEEF, 32'h1C00_0018));
        @(negedge clk);
        `CHK("st_en", data_sram_en, 1'b1);
        `CHK("st_we", data_sram_we, 4'hF);
        `CHK("st_addr", data_sram_addr, 32'h104);
        `CHK("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
        step();

        ms_allowin = 1'b0;
        send(mk(ADD, 0, 1, 0, 1, 5'd9, 32'h200, 8, 0, 32'h1C00_001C));
        @(negedge clk);
        `CHK("ld_we", data_sram_we, 4'h0);
        `CHK("ld_res_from_mem", es_to_ms_bus[70], 1'b1);
        `CHK("ld_exe_res_from_mem", exe_res_from_mem, 1'b1);
        step();
        step();
        ms_allowin = 1'b1;
        step();

        alu_vec[0]  = mk(SUB,  0, 0, 0, 1, 1, 32'd3, 32'd5, 0, 32'h20);
        alu_vec[1]  = mk(SLT,  0, 0, 0, 1, 2, 32'hFFFF_FFFF, 32'd1, 0, 32'h24);
        alu_vec[2]  = mk(SLTU, 0, 0, 0, 1, 3, 32'hFFFF_FFFF, 32'd1, 0, 32'h28);
        alu_vec[3]  = mk(AND,  0, 0, 0, 1, 4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'h2C);
        alu_vec[4]  = mk(NOR,  0, 0, 0, 1, 5, 32'hF0F0_0000, 32'h0000_000F, 0, 32'h30);
        alu_vec[5]  = mk(OR,   0, 0, 0, 1, 6, 32'hA000_0001, 32'h0500_0010, 0, 32'h34);
        alu_vec[6]  = mk(XOR,  0, 0, 0, 1, 7, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 32'h38);
        alu_vec[7]  = mk(SLL,  0, 0, 0, 1, 8, 32'h0000_0003, 32'h0000_0024, 0, 32'h3C);
        alu_vec[8]  = mk(SRL,  0, 0, 0, 1, 9, 32'h8000_0000, 32'd31, 0, 32'h40);
        alu_vec[9]  = mk(SRA,  0, 0, 0, 1, 10, 32'h8000_0000, 32'd4, 0, 32'h44);
        alu_vec[10] = mk(LUI,  0, 0, 0, 1, 11, 32'h1111_1111, 32'hABCD_E000, 0, 32'h48);
        alu_vec[11] = mk(12'h000, 0, 0, 0, 0, 12, 32'h1234_5678, 32'h9, 0, 32'h4C);
        for (int i = 0; i < 12; i++) send(alu_vec[i]);
        step();

        ms_allowin = 1'b0;
        send(mk(0, DIVWU, 0, 0, 1, 5'd13, 32'd100, 32'd7, 0, 32'h50));
        run_div("div_stall", 32'd14);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            `CHK("stall_hold_result", es_to_ms_bus[63:32], 32'd14);
            `CHK("stall_hold_valid", es_to_ms_valid, 1'b1);
        end
        step();
        ms_allowin = 1'b1;
        xfers = 0;
        repeat (3) begin
            @(negedge clk);
            if (es_to_ms_valid && ms_allowin) xfers++;
            step();
        end
        `CHK("stall_transfers", xfers, 1);

        send(mk(0, DIVW, 0, 0, 1, 5'd14, 32'hFFFF_FF9C, 32'd9, 0, 32'h54));
        send(mk(0, MODW, 0, 0, 1, 5'd15, 32'hFFFF_FF9C, 32'd9, 0, 32'h58));
        run_div("b2b_second", 32'hFFFF_FFFF);
        step();

        send(mk(0, DIVW, 0, 0, 1, 5'd16, 32'd1000, 32'd3, 0, 32'h5C));
        repeat (10) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        `CHK("rst_busy_valid", es_to_ms_valid, 1'b0);
        `CHK("rst_busy_allowin", es_allowin, 1'b1);
        `CHK("rst_busy_dest", EXE_dest, 5'd0);
        step();
        reset = 1'b0;
        send(mk(0, MODWU, 0, 0, 1, 5'd17, 32'd1000, 32'd3, 0, 32'h60));
        run_div("after_rst", 32'd1);
        step();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage LoongArch pipeline, between decode (ID) and memory (MS). It registers the ID-to-ES bus and runs the single-cycle ALU. It runs a 32-iteration restoring divider for div/mod instructions and issues the synchronous data-SRAM request for ld.w/st.w. It forwards a 71-bit bus to MS and exports its destination for RAW blocking in ID.

## Interface
Parameters: none. Bus widths are fixed: DS_TO_ES_BUS_WD = 152, ES_TO_MS_BUS_WD = 71.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ms_allowin  in  1  MS can accept this cycle
- es_allowin  out  1  ES can accept this cycle
- ds_to_es_valid  in  1  ID offers an instruction
- ds_to_es_bus  in  152  {alu_op[11:0] 151:140, div_op[3:0] 139:136, load_op 135, mem_we 134, gr_we 133, dest[4:0] 132:128, src1[31:0] 127:96, src2[31:0] 95:64, rkd_value[31:0] 63:32, pc[31:0] 31:0}
- es_to_ms_valid  out  1  valid to MS
- es_to_ms_bus  out  71  {res_from_mem 70, gr_we 69, dest 68:64, result 63:32, pc 31:0}
- data_sram_en  out  1  SRAM access enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- EXE_dest  out  5  dest & {5{es_valid}}
- exe_gr_we  out  1  es_valid & gr_we
- exe_res_from_mem  out  1  es_valid & load_op; ID uses it for load-use blocking

## Operation
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
  - On es_allowin, es_valid <= ds_to_es_valid.
  - The bus register loads only when ds_to_es_valid && es_allowin.
- alu_op is one-hot:
  - Bits 0..11: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2[4:0] as the amount and shift src1.
  - lui outputs src2.
  - All-zero alu_op gives 0.
- div_op is one-hot; bits 0..3: div.w, mod.w, div.wu, mod.wu. Any bit set selects the divider result over the ALU.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when es_valid && |div_op. Latch |src1|, |src2| (raw values for unsigned ops) and the sign flags; clear the remainder; count = 0.
  - BUSY does one restoring step per cycle: shift the remainder left by one and bring in the next dividend bit from the MSB; subtract if >= divisor; the quotient bit is 1 on subtract. count++. At count == 31 -> DONE.
  - DONE -> IDLE on es_to_ms_valid && ms_allowin.
  - es_ready_go = !(|div_op) || state == DONE.
- Signed fix-up:
  - Quotient is negated if src1[31] ^ src2[31].
  - Remainder is negated if src1[31].
- Divide by zero (any div op): quotient = 0xFFFFFFFF, remainder = src1, both returned unmodified.
- 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0, as 32-bit wrap.
- Memory:
  - data_sram_addr = ALU add result.
  - data_sram_en = es_valid && (load_op || mem_we).
  - data_sram_we = {4{es_valid && mem_we}}.
  - data_sram_wdata = rkd_value.
  - Word accesses only; no alignment check.
- Output bus: res_from_mem = load_op; result = divider or ALU value.

## Timing
- Reset: es_valid = 0, FSM = IDLE, all valid-qualified outputs 0, es_allowin = 1. The bus register keeps its contents.
- Reset while BUSY aborts the division; the FSM returns to IDLE the next cycle.
- Non-div instructions: ready_go in the same cycle, so one cycle in ES when ms_allowin = 1.
- Division, counting cycle 0 as the first cycle with es_valid:
  - Cycles 1..32: BUSY.
  - Cycle 33: DONE, es_to_ms_valid = 1.
  - Minimum residency is 34 cycles.
- A divide held in DONE by ms_allowin = 0 stays in DONE with a stable result.
- Back-to-back divides: the second enters IDLE the cycle after the first leaves and starts again.
- Load: SRAM read issued in ES, rdata valid in MS the following cycle. If stalled, the read repeats each cycle at the same address.
- A store stalled in ES rewrites identical data; this is harmless.
- es_to_ms_bus is combinational from the bus register and divider; it is not registered again.

## Test plan
- add: src1 = 5, src2 = 7, ms_allowin = 1 -> one cycle later es_to_ms_valid = 1, result = 12, EXE_dest = dest.
- div.w: 0xFFFFFFF9 / 2 (-7 / 2) -> result 0xFFFFFFFD on cycle 33 exactly; es_allowin = 0 on cycles 0..32. mod.w with the same operands -> 0xFFFFFFFF.
- div.wu by 0 -> 0xFFFFFFFF. mod.wu 0x1234 by 0 -> 0x1234. div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- st.w: src1 = 0x100, src2 = 4, rkd = 0xDEADBEEF -> en = 1, we = 4'hF, addr = 0x104, wdata = 0xDEADBEEF. ld.w -> we = 0, res_from_mem = 1, exe_res_from_mem = 1.
- Divide reaches DONE while ms_allowin = 0 for 5 cycles -> result held constant, no duplicate transfer, exactly one handshake when ms_allowin rises.
- Reset asserted at BUSY cycle 10 -> next cycle es_valid = 0 and FSM IDLE. A new divide issued afterwards completes in 34 cycles with the correct result.
